// File: rtl/nm_shift_multiplier_if.sv
// Handshake and operand/result bundle for the shift-and-add multiplier.
// The requester (master) drives start and the operands; the multiplier (slave) returns the result.
interface nm_shift_multiplier_if #(
  parameter int WIDTH = 23
);
  logic                 start;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 sign_a;
  logic                 sign_b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 product_sign;

  modport master (
    output start, a_mag, b_mag, sign_a, sign_b,
    input  busy, done, product, product_sign
  );

  modport slave (
    input  start, a_mag, b_mag, sign_a, sign_b,
    output busy, done, product, product_sign
  );
endinterface

// File: rtl/nm_shift_multiplier.sv
// Sequential shift-and-add multiplier on unsigned magnitudes, one partial product per clock.
// The result is sign-magnitude; a zero product always carries a positive sign.
module nm_shift_multiplier #(
  parameter int WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  nm_shift_multiplier_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     mcand;
  // {carry, upper, lower}: the carry bit keeps the upper add from losing its MSB
  logic [2*WIDTH:0]     acc;
  logic [2*WIDTH:0]     acc_step;
  logic [WIDTH:0]       upper_sum;
  logic                 sign_r;
  logic                 last_iter;
  logic [2*WIDTH-1:0]   product_r;
  logic                 product_sign_r;

  function automatic logic result_sign(input logic s, input logic [2*WIDTH-1:0] mag);
    return s & (|mag);
  endfunction

  always_comb begin
    upper_sum = acc[2*WIDTH:WIDTH];
    if (acc[0]) begin
      upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    end
    acc_step  = {1'b0, upper_sum, acc[WIDTH-1:1]};
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      mcand          <= '0;
      acc            <= '0;
      sign_r         <= 1'b0;
      product_r      <= '0;
      product_sign_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.a_mag;
            acc    <= {{(WIDTH + 1){1'b0}}, bus.b_mag};
            sign_r <= bus.sign_a ^ bus.sign_b;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
          // Result registers only move on the final iteration, so they hold through the next run
          if (last_iter) begin
            product_r      <= acc_step[2*WIDTH-1:0];
            product_sign_r <= result_sign(sign_r, acc_step[2*WIDTH-1:0]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state == RUN);
  assign bus.done         = (state == DONE);
  assign bus.product      = product_r;
  assign bus.product_sign = product_sign_r;

endmodule

// File: tb/tb_nm_shift_multiplier.sv
// Self-checking bench for nm_shift_multiplier: directed scenarios plus randomized operands
// compared against plain-arithmetic multiplication.
module tb_nm_shift_multiplier;

  localparam int WIDTH   = 23;
  localparam int LATENCY = 23;
  localparam int BOUND   = 60;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  nm_shift_multiplier_if #(.WIDTH(WIDTH)) mif ();

  nm_shift_multiplier #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*WIDTH-1:0] ref_product(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint unsigned pa;
    pa = longint'(a) * longint'(b);
    return pa[2*WIDTH-1:0];
  endfunction

  function automatic logic ref_sign(input logic sa, input logic sb, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
    return (sa != sb) && (a != 0) && (b != 0);
  endfunction

  // Presents one start pulse covering exactly one rising edge; returns at the negedge after it.
  task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sa, input logic sb);
    @(negedge clk);
    mif.a_mag  = a;
    mif.b_mag  = b;
    mif.sign_a = sa;
    mif.sign_b = sb;
    mif.start  = 1'b1;
    @(negedge clk);
    mif.start  = 1'b0;
  endtask

  // Waits (bounded) for done, counting negedges elapsed and negedges at which busy was seen.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = mif.busy ? 1 : 0;
    while (!mif.done && cycles < BOUND) begin
      @(negedge clk);
      cycles++;
      if (mif.busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    mif.start  = 1'b0;
    mif.a_mag  = '0;
    mif.b_mag  = '0;
    mif.sign_a = 1'b0;
    mif.sign_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", mif.busy); end
    checks++;
    if (mif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", mif.done); end
    checks++;
    if (mif.product !== '0) begin errors++; $display("FAIL reset_product got %h want 0", mif.product); end
    checks++;
    if (mif.product_sign !== 1'b0) begin errors++; $display("FAIL reset_sign got %b want 0", mif.product_sign); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mif.done !== 1'b0 || mif.busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", mif.busy, mif.done);
    end
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    do_start(23'd3, 23'd5, 1'b0, 1'b0);
    checks++;
    if (mif.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %b want 1", mif.busy); end
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== LATENCY) begin errors++; $display("FAIL basic_latency got %0d want %0d", cyc, LATENCY); end
    checks++;
    if (bcyc !== LATENCY) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", bcyc, LATENCY); end
    checks++;
    if (mif.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got %b want 0", mif.busy); end
    checks++;
    if (mif.product !== 46'd15) begin errors++; $display("FAIL basic_product got %0d want 15", mif.product); end
    checks++;
    if (mif.product_sign !== 1'b0) begin errors++; $display("FAIL basic_sign got %b want 0", mif.product_sign); end
    @(negedge clk);
    checks++;
    if (mif.done !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle got %b want 0", mif.done); end
    repeat (3) @(negedge clk);
    checks++;
    if (mif.product !== 46'd15) begin errors++; $display("FAIL basic_hold got %0d want 15", mif.product); end
  endtask

  task automatic test_max();
    int cyc, bcyc;
    do_start(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0);
    wait_done(cyc, bcyc);
    checks++;
    if (mif.product !== 46'h3FFFFF000001) begin
      errors++; $display("FAIL max_product got %h want 3fffff000001", mif.product);
    end
    checks++;
    if (mif.product_sign !== 1'b0) begin errors++; $display("FAIL max_sign got %b want 0", mif.product_sign); end
  endtask

  task automatic test_signs();
    int cyc, bcyc;
    do_start(23'd7, 23'd6, 1'b1, 1'b0);
    wait_done(cyc, bcyc);
    checks++;
    if (mif.product !== 46'd42) begin errors++; $display("FAIL sign_mixed_product got %0d want 42", mif.product); end
    checks++;
    if (mif.product_sign !== 1'b1) begin errors++; $display("FAIL sign_mixed got %b want 1", mif.product_sign); end
    do_start(23'd7, 23'd6, 1'b1, 1'b1);
    wait_done(cyc, bcyc);
    checks++;
    if (mif.product !== 46'd42) begin errors++; $display("FAIL sign_both_product got %0d want 42", mif.product); end
    checks++;
    if (mif.product_sign !== 1'b0) begin errors++; $display("FAIL sign_both got %b want 0", mif.product_sign); end
  endtask

  task automatic test_zero();
    int cyc, bcyc;
    do_start(23'd0, 23'd1234, 1'b1, 1'b0);
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== LATENCY) begin errors++; $display("FAIL zero_latency got %0d want %0d", cyc, LATENCY); end
    checks++;
    if (mif.product !== '0) begin errors++; $display("FAIL zero_product got %0d want 0", mif.product); end
    checks++;
    if (mif.product_sign !== 1'b0) begin errors++; $display("FAIL zero_sign got %b want 0", mif.product_sign); end
  endtask

  task automatic test_ignore_start();
    int cyc, bcyc, extra;
    do_start(23'd3, 23'd5, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    mif.a_mag  = 23'd9;
    mif.b_mag  = 23'd9;
    mif.sign_a = 1'b1;
    mif.start  = 1'b1;
    @(negedge clk);
    mif.start  = 1'b0;
    wait_done(cyc, bcyc);
    checks++;
    if (mif.product !== 46'd15) begin errors++; $display("FAIL ignore_product got %0d want 15", mif.product); end
    checks++;
    if (mif.product_sign !== 1'b0) begin errors++; $display("FAIL ignore_sign got %b want 0", mif.product_sign); end
    extra = 0;
    repeat (35) begin
      @(negedge clk);
      if (mif.done || mif.busy) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL ignore_no_second_run got %0d active cycles want 0", extra); end
    do_start(23'd9, 23'd9, 1'b0, 1'b0);
    wait_done(cyc, bcyc);
    checks++;
    if (mif.product !== 46'd81) begin errors++; $display("FAIL after_ignore_product got %0d want 81", mif.product); end
  endtask

  task automatic test_async_reset();
    int cyc, bcyc, seen;
    do_start(23'd100, 23'd100, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mif.busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", mif.busy); end
    checks++;
    if (mif.done !== 1'b0) begin errors++; $display("FAIL areset_done got %b want 0", mif.done); end
    checks++;
    if (mif.product !== '0) begin errors++; $display("FAIL areset_product got %0d want 0", mif.product); end
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (mif.done || mif.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL areset_no_done got %0d active cycles want 0", seen); end
    do_start(23'd2, 23'd2, 1'b0, 1'b0);
    wait_done(cyc, bcyc);
    checks++;
    if (mif.product !== 46'd4) begin errors++; $display("FAIL areset_restart got %0d want 4", mif.product); end
  endtask

  task automatic test_random();
    int cyc, bcyc;
    logic [WIDTH-1:0]   a, b;
    logic               sa, sb;
    logic [2*WIDTH-1:0] prev;
    prev = mif.product;
    for (int i = 0; i < 24; i++) begin
      a  = WIDTH'($urandom());
      b  = WIDTH'($urandom());
      if (i % 8 == 3) a = '0;
      if (i % 8 == 5) b = '0;
      if (i % 8 == 6) a = {WIDTH{1'b1}};
      sa = 1'($urandom());
      sb = 1'($urandom());
      do_start(a, b, sa, sb);
      // Scramble operand inputs mid-run; they must not matter
      mif.a_mag  = WIDTH'($urandom());
      mif.b_mag  = WIDTH'($urandom());
      mif.sign_a = ~sa;
      checks++;
      if (mif.product !== prev) begin
        errors++; $display("FAIL rand_hold[%0d] got %h want %h", i, mif.product, prev);
      end
      wait_done(cyc, bcyc);
      checks++;
      if (cyc !== LATENCY) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, cyc, LATENCY); end
      checks++;
      if (mif.product !== ref_product(a, b)) begin
        errors++; $display("FAIL rand_product[%0d] a=%h b=%h got %h want %h", i, a, b, mif.product, ref_product(a, b));
      end
      checks++;
      if (mif.product_sign !== ref_sign(sa, sb, a, b)) begin
        errors++; $display("FAIL rand_sign[%0d] got %b want %b", i, mif.product_sign, ref_sign(sa, sb, a, b));
      end
      prev = ref_product(a, b);
      repeat (i % 3) @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_max();
    test_signs();
    test_zero();
    test_ignore_start();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nm_shift_multiplier.md
Name: nm_shift_multiplier

Overview:
- Sequential shift-and-add multiplier. Sits directly downstream of the two's-complement magnitude stage.
- Consumes two unsigned 23-bit magnitudes and their original sign bits.
- Produces a 46-bit product magnitude plus a product sign, one partial product per clock.
- Output is sign-magnitude, so a later complement stage can restore two's-complement form.

Parameters:
- WIDTH, 23, operand magnitude width in bits. Product width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request a multiply; sampled only in IDLE.
- a_mag  input  WIDTH  multiplicand magnitude, captured on accepted start.
- b_mag  input  WIDTH  multiplier magnitude, captured on accepted start.
- sign_a  input  1  sign of original operand A, captured on accepted start.
- sign_b  input  1  sign of original operand B, captured on accepted start.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse: product and product_sign are valid.
- product  output  2*WIDTH  unsigned product magnitude; held until the next accepted start.
- product_sign  output  1  sign_a XOR sign_b, forced 0 when product is zero.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, iteration counter=0.
  - busy=0, done=0, product=0, product_sign=0, internal operand registers=0.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at an edge: capture a_mag into multiplicand register, b_mag into lower half of accumulator, sign into sign register.
  - Clear upper accumulator (WIDTH+1 bits including carry) and counter; go to RUN.
  - start=0: remain in IDLE; outputs hold.
- RUN (busy=1), one iteration per edge:
  - If accumulator bit 0 = 1, upper = upper + multiplicand (WIDTH+1-bit add, no overflow loss).
  - Shift the whole {carry, upper, lower} right by 1; increment counter.
  - After the iteration with counter = WIDTH-1: go to DONE; load product from the 2*WIDTH accumulator bits.
  - Load product_sign = sign XOR, zeroed if the accumulator result is 0.
- DONE: done=1, busy=0 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: start sampled at edge E0; iterations at E1..E23; done high during the cycle after E23. A new start is accepted no earlier than the edge after done.
- start while busy or done is ignored; it is not queued. Operand input changes during RUN have no effect.
- product and product_sign:
  - change only at the transition into DONE;
  - hold their values in IDLE and RUN until the next result;
  - reset to 0 only by rst.
- Fixed latency regardless of operand values; no early termination on zero operands.
- Reset asserted mid-RUN aborts immediately to reset values; no done pulse is produced for the aborted operation.
- Arithmetic is unsigned on magnitudes. Max result (2^23-1)^2 = 0x3FFFFF000001 must fit without truncation.

Test Plan:
- Reset then start with a_mag=3, b_mag=5, signs 0 -> busy for 23 cycles, done pulse 23 cycles after start edge, product=15, product_sign=0.
- a_mag=0x7FFFFF, b_mag=0x7FFFFF -> product=0x3FFFFF000001, product_sign=0; verifies carry bit in accumulator.
- a_mag=7, sign_a=1, b_mag=6, sign_b=0 -> product=42, product_sign=1. Repeat with both signs 1 -> product_sign=0.
- a_mag=0, sign_a=1, b_mag=1234, sign_b=0 -> product=0, product_sign=0 (zero sign forcing).
- Start 3x5, pulse start again at cycle 10 with 9x9 -> second start ignored, done once with product=15. Then start 9x9 after done -> product=81.
- Start 100x100, drive rst=0 at cycle 12 asynchronously:
  - busy, done, product immediately 0;
  - after release, no done pulse until a new start;
  - new start 2x2 yields product=4.
